// File: rtl/encoder_acq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// encoder_acq_ctrl_pkg
//   Shared definitions for the encoder acquisition control stage and the
//   downstream sampler: state encoding, default filter length and timeout,
//   bus widths, and small arithmetic helpers used by the run sequencer.
// ---------------------------------------------------------------------------
package encoder_acq_ctrl_pkg;

    localparam int ADDR_W = 20;   // RAM base address width
    localparam int CNT_W  = 8;    // sync / revolution counter width

    localparam int          FILT_LEN_DEF    = 4;
    localparam int          TO_W_DEF        = 24;
    localparam logic [23:0] TIMEOUT_CYC_DEF = 24'd10_000_000;

    // Plain binary 2-bit encoding; the sampler decodes the same values.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_RUN  = 2'b10,
        ST_DONE = 2'b11
    } acq_state_e;

    // Count of sync rising edges that completes a run: one edge opens the
    // first revolution, each further edge closes one, so the run ends at
    // eff_target + 1. A target of 0 is treated as 1. One extra bit keeps
    // a target of 255 from wrapping.
    function automatic logic [CNT_W:0] run_limit(input logic [CNT_W-1:0] rev);
        if (rev == '0) begin
            return (CNT_W+1)'(2);
        end
        return {1'b0, rev} + (CNT_W+1)'(1);
    endfunction

    // Saturating increment for the sync counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == '1) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/encoder_acq_ctrl_if.sv
// ---------------------------------------------------------------------------
// encoder_acq_ctrl_if
//   Bus from the acquisition control stage to the sampler / RAM-write block.
//     ch_sgn_in   filtered encoder signal
//     ch_sync_in  filtered encoder index / sync
//     sample_en   sampler enable
//     sample_end  1 = MCU owns the external RAM
//     sync_cnt    filtered sync rising edges seen in this run (saturating)
//     addr_base   RAM base address latched at run start
//   master: the control stage (drives everything); slave: the sampler.
// ---------------------------------------------------------------------------
interface encoder_acq_ctrl_if;
    import encoder_acq_ctrl_pkg::*;

    logic              ch_sgn_in;
    logic              ch_sync_in;
    logic              sample_en;
    logic              sample_end;
    logic [CNT_W-1:0]  sync_cnt;
    logic [ADDR_W-1:0] addr_base;

    modport master (
        output ch_sgn_in,
        output ch_sync_in,
        output sample_en,
        output sample_end,
        output sync_cnt,
        output addr_base
    );

    modport slave (
        input ch_sgn_in,
        input ch_sync_in,
        input sample_en,
        input sample_end,
        input sync_cnt,
        input addr_base
    );

endinterface

// File: rtl/encoder_acq_ctrl_sig_filter.sv
// ---------------------------------------------------------------------------
// sig_filter
//   Two-flop synchroniser followed by a stable-count glitch filter.
//   The output follows the synchronised input only after the two have
//   differed for FILT_LEN consecutive cycles; shorter pulses are dropped.
//   Raw edge to output latency is 2 + FILT_LEN cycles.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset (output and counter clear to 0)
//     raw    asynchronous input
//     filt   filtered, clock-domain-safe output
//   FILT_LEN must lie in 1..15 (4-bit stable counter).
// ---------------------------------------------------------------------------
module sig_filter
    import encoder_acq_ctrl_pkg::*;
#(
    parameter int FILT_LEN = FILT_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic filt
);

    localparam logic [3:0] CNT_LAST = 4'(FILT_LEN - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       filt_q;
    logic [3:0] stable_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of its neighbours; blocking here would
    // collapse the two synchroniser stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            filt_q   <= 1'b0;
            stable_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            if (sync2_q == filt_q) begin
                stable_q <= '0;
            end else if (stable_q == CNT_LAST) begin
                // The input has disagreed for FILT_LEN cycles in a row.
                filt_q   <= ~filt_q;
                stable_q <= '0;
            end else begin
                stable_q <= stable_q + 4'd1;
            end
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/encoder_acq_ctrl.sv
// ---------------------------------------------------------------------------
// encoder_acq_ctrl
//   Upstream control stage for the encoder sampler. Conditions the raw
//   encoder signal and sync, and sequences one acquisition run per MCU
//   request: IDLE -> ARM (wait first sync) -> RUN (count revolutions) ->
//   DONE. The run ends on reaching the revolution target, on a sync
//   timeout, or on an MCU abort; RAM ownership returns to the MCU then.
//   Ports:
//     clk, mcu_n_rst       clock, asynchronous active-low reset
//     ch_sgn_raw           raw encoder signal (asynchronous)
//     ch_sync_raw          raw encoder index / sync (asynchronous)
//     mcu_start            request level; rise starts, fall aborts
//     mcu_addr_base        RAM base address, latched at start
//     rev_target           revolutions to capture (0 treated as 1), live
//     smp                  sampler bus (master side)
//     busy                 run in progress (ARM or RUN)
//     timeout_flag         last run ended on sync timeout
//     abort_flag           last run ended on MCU abort
// ---------------------------------------------------------------------------
module encoder_acq_ctrl
    import encoder_acq_ctrl_pkg::*;
#(
    parameter int              FILT_LEN    = FILT_LEN_DEF,
    parameter int              TO_W        = TO_W_DEF,
    parameter logic [TO_W-1:0] TIMEOUT_CYC = TO_W'(TIMEOUT_CYC_DEF)
) (
    input  logic                clk,
    input  logic                mcu_n_rst,
    input  logic                ch_sgn_raw,
    input  logic                ch_sync_raw,
    input  logic                mcu_start,
    input  logic [ADDR_W-1:0]   mcu_addr_base,
    input  logic [CNT_W-1:0]    rev_target,
    encoder_acq_ctrl_if.master  smp,
    output logic                busy,
    output logic                timeout_flag,
    output logic                abort_flag
);

    localparam logic [TO_W-1:0] TO_LAST = TIMEOUT_CYC - TO_W'(1);

    // -----------------------------------------------------------------
    // Input conditioning
    // -----------------------------------------------------------------
    logic sgn_filt;
    logic sync_filt;

    sig_filter #(.FILT_LEN(FILT_LEN)) u_sgn_filt (
        .clk   (clk),
        .rst_n (mcu_n_rst),
        .raw   (ch_sgn_raw),
        .filt  (sgn_filt)
    );

    sig_filter #(.FILT_LEN(FILT_LEN)) u_sync_filt (
        .clk   (clk),
        .rst_n (mcu_n_rst),
        .raw   (ch_sync_raw),
        .filt  (sync_filt)
    );

    // mcu_start is a slow level from firmware: synchronise only, no filter.
    logic start_s1_q;
    logic start_s2_q;
    logic start_prev_q;
    logic sync_prev_q;

    always_ff @(posedge clk or negedge mcu_n_rst) begin
        if (!mcu_n_rst) begin
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_prev_q <= 1'b0;
            sync_prev_q  <= 1'b0;
        end else begin
            start_s1_q   <= mcu_start;
            start_s2_q   <= start_s1_q;
            start_prev_q <= start_s2_q;
            sync_prev_q  <= sync_filt;
        end
    end

    logic sync_rise;
    logic start_rise;
    logic start_fall;

    assign sync_rise  =  sync_filt  & ~sync_prev_q;
    assign start_rise =  start_s2_q & ~start_prev_q;
    assign start_fall = ~start_s2_q &  start_prev_q;

    // -----------------------------------------------------------------
    // Run sequencer
    // -----------------------------------------------------------------
    acq_state_e        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [TO_W-1:0]   to_q,     to_d;
    logic              en_q,     en_d;
    logic              end_q,    end_d;
    logic              tof_q,    tof_d;
    logic              abf_q,    abf_d;

    logic [CNT_W-1:0]  cnt_inc;
    logic              run_done;
    logic              to_hit;

    assign cnt_inc  = sat_inc(cnt_q);
    assign run_done = ({1'b0, cnt_inc} == run_limit(rev_target));
    assign to_hit   = (to_q == TO_LAST);

    // NOTE: every signal driven here gets its hold value first; any path
    // that left one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        to_d    = to_q;
        en_d    = en_q;
        end_d   = end_q;
        tof_d   = tof_q;
        abf_d   = abf_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                en_d  = 1'b0;
                end_d = 1'b1;
                if (start_rise) begin
                    addr_d  = mcu_addr_base;
                    cnt_d   = '0;
                    to_d    = '0;
                    tof_d   = 1'b0;
                    abf_d   = 1'b0;
                    en_d    = 1'b1;
                    end_d   = 1'b0;
                    state_d = ST_ARM;
                end
            end

            ST_ARM, ST_RUN: begin
                // Priority: abort, then sync edge, then timeout. Any sync
                // edge restarts the no-sync timer, so it also beats timeout.
                if (start_fall) begin
                    abf_d   = 1'b1;
                    en_d    = 1'b0;
                    end_d   = 1'b1;
                    state_d = ST_DONE;
                end else if (sync_rise) begin
                    to_d = '0;
                    if (state_q == ST_ARM) begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_inc;
                        if (run_done) begin
                            en_d    = 1'b0;
                            end_d   = 1'b1;
                            state_d = ST_DONE;
                        end
                    end
                end else if (to_hit) begin
                    tof_d   = 1'b1;
                    en_d    = 1'b0;
                    end_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge mcu_n_rst) begin
        if (!mcu_n_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            to_q    <= '0;
            en_q    <= 1'b0;
            end_q   <= 1'b1;
            tof_q   <= 1'b0;
            abf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            to_q    <= to_d;
            en_q    <= en_d;
            end_q   <= end_d;
            tof_q   <= tof_d;
            abf_q   <= abf_d;
        end
    end

    // -----------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------
    assign smp.ch_sgn_in  = sgn_filt;
    assign smp.ch_sync_in = sync_filt;
    assign smp.sample_en  = en_q;
    assign smp.sample_end = end_q;
    assign smp.sync_cnt   = cnt_q;
    assign smp.addr_base  = addr_q;

    assign busy         = (state_q == ST_ARM) || (state_q == ST_RUN);
    assign timeout_flag = tof_q;
    assign abort_flag   = abf_q;

endmodule

// File: tb/tb_encoder_acq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_encoder_acq_ctrl
//   Self-checking bench for encoder_acq_ctrl (FILT_LEN=4, TIMEOUT_CYC=1000).
//   Inputs change 1 time unit after a rising edge and outputs are sampled
//   at that same point, so "tick(n)" means n clock edges have elapsed.
//   The reference model tracks a run only as busy/done plus counters and
//   flags, updated once per complete sync pulse or MCU action.
// ---------------------------------------------------------------------------
module tb_encoder_acq_ctrl;

    localparam int FILT = 4;
    localparam int TOC  = 1000;

    logic        clk = 1'b0;
    logic        mcu_n_rst;
    logic        ch_sgn_raw;
    logic        ch_sync_raw;
    logic        mcu_start;
    logic [19:0] mcu_addr_base;
    logic [7:0]  rev_target;
    logic        busy;
    logic        timeout_flag;
    logic        abort_flag;

    encoder_acq_ctrl_if smp_if ();

    encoder_acq_ctrl #(
        .FILT_LEN    (FILT),
        .TO_W        (24),
        .TIMEOUT_CYC (24'd1000)
    ) dut (
        .clk           (clk),
        .mcu_n_rst     (mcu_n_rst),
        .ch_sgn_raw    (ch_sgn_raw),
        .ch_sync_raw   (ch_sync_raw),
        .mcu_start     (mcu_start),
        .mcu_addr_base (mcu_addr_base),
        .rev_target    (rev_target),
        .smp           (smp_if),
        .busy          (busy),
        .timeout_flag  (timeout_flag),
        .abort_flag    (abort_flag)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    bit        m_busy;
    int        m_cnt;
    int        m_addr;
    bit        m_to;
    bit        m_ab;

    task automatic model_reset();
        m_busy = 0; m_cnt = 0; m_addr = 0; m_to = 0; m_ab = 0;
    endtask

    task automatic model_start(input int addr);
        if (!m_busy) begin
            m_busy = 1; m_cnt = 0; m_addr = addr; m_to = 0; m_ab = 0;
        end
    endtask

    // One complete sync pulse while a run is active.
    task automatic model_sync();
        int lim;
        if (m_busy) begin
            lim   = (rev_target == 0) ? 2 : int'(rev_target) + 1;
            m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            if (m_cnt == lim) m_busy = 0;
        end
    endtask

    task automatic model_abort();
        if (m_busy) begin
            m_busy = 0; m_ab = 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/busy"},  busy,                 m_busy);
        check({tag, "/en"},    smp_if.sample_en,     m_busy);
        check({tag, "/end"},   smp_if.sample_end,    !m_busy);
        check({tag, "/cnt"},   smp_if.sync_cnt,      m_cnt);
        check({tag, "/addr"},  smp_if.addr_base,     m_addr);
        check({tag, "/tof"},   timeout_flag,         m_to);
        check({tag, "/abf"},   abort_flag,           m_ab);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_start(input string tag, input logic [19:0] addr, input logic [7:0] rev);
        mcu_addr_base = addr;
        rev_target    = rev;
        mcu_start     = 1'b1;
        tick(3);                       // 2 sync stages + state register
        model_start(addr);
        check_all(tag);
    endtask

    task automatic do_stop(input string tag);
        mcu_start = 1'b0;
        tick(3);
        model_abort();
        check_all(tag);
        tick(2);
    endtask

    task automatic sync_pulse(input string tag, input int w, input int gap);
        ch_sync_raw = 1'b1;
        tick(w);
        ch_sync_raw = 1'b0;
        tick(gap);
        model_sync();
        check_all(tag);
    endtask

    task automatic sync_glitch(input string tag, input int w);
        ch_sync_raw = 1'b1;
        tick(w);
        ch_sync_raw = 1'b0;
        tick(10);
        check_all(tag);
    endtask

    // Drive a sgn pulse of width w and check the filtered trace cycle by
    // cycle: it rises 2+FILT edges after the raw rise and falls 2+FILT
    // edges after the raw fall, and only if w >= FILT.
    task automatic sgn_trace(input string tag, input int w);
        bit exp;
        ch_sgn_raw = 1'b1;
        for (int t = 1; t <= w + 10; t++) begin
            if (t == w + 1) ch_sgn_raw = 1'b0;
            @(posedge clk);
            #1;
            exp = (w >= FILT) && (t >= 2 + FILT) && (t < w + 2 + FILT);
            check($sformatf("%s_t%0d", tag, t), smp_if.ch_sgn_in, exp);
            if (t == w) ch_sgn_raw = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        mcu_n_rst     = 1'b0;
        ch_sgn_raw    = 1'b0;
        ch_sync_raw   = 1'b0;
        mcu_start     = 1'b0;
        mcu_addr_base = '0;
        rev_target    = '0;
        model_reset();
        tick(3);
        check_all("rst");
        check("rst/sgn",  smp_if.ch_sgn_in,  0);
        check("rst/sync", smp_if.ch_sync_in, 0);
        mcu_n_rst = 1'b1;
        tick(3);

        // ---- glitch filter on sgn ----
        sgn_trace("glitch3", 3);
        ch_sgn_raw = 1'b1;
        tick(5);
        check("sgn10_at5", smp_if.ch_sgn_in, 0);
        tick(1);
        check("sgn10_at6", smp_if.ch_sgn_in, 1);
        tick(4);
        ch_sgn_raw = 1'b0;
        tick(5);
        check("sgn10_fall5", smp_if.ch_sgn_in, 1);
        tick(1);
        check("sgn10_fall6", smp_if.ch_sgn_in, 0);
        tick(4);
        for (int i = 0; i < 6; i++) sgn_trace("sgn_rnd", $urandom_range(1, 8));

        // ---- normal run, rev_target = 2 ----
        do_start("norm_start", 20'h01000, 8'd2);
        check("norm_addr", smp_if.addr_base, 20'h01000);
        check("norm_en",   smp_if.sample_en, 1);
        sync_pulse("norm_s1", 6, 10);
        check("norm_cnt1", smp_if.sync_cnt, 1);
        sync_pulse("norm_s2", 6, 10);
        check("norm_cnt2", smp_if.sync_cnt, 2);
        ch_sync_raw = 1'b1;
        tick(6);
        check("norm_pre_end", smp_if.sample_end, 0);
        tick(1);
        check("norm_end", smp_if.sample_end, 1);
        check("norm_en0", smp_if.sample_en, 0);
        check("norm_cnt3", smp_if.sync_cnt, 3);
        ch_sync_raw = 1'b0;
        tick(10);
        model_sync();
        check_all("norm_done");
        do_stop("norm_stop");

        // ---- timeout with no sync ----
        do_start("to_start", 20'h0ABCD, 8'd3);
        tick(TOC - 1);
        check("to_pre", busy, 1);
        tick(1);
        m_busy = 0;
        m_to   = 1;
        check_all("to_done");
        check("to_flag", timeout_flag, 1);
        do_stop("to_stop");

        // ---- abort in RUN with sync_cnt = 2, then restart ----
        do_start("ab_start", 20'h12345, 8'd4);
        sync_pulse("ab_s1", 5, 9);
        sync_pulse("ab_s2", 5, 9);
        do_stop("ab_stop");
        check("ab_flag", abort_flag, 1);
        check("ab_cnt", smp_if.sync_cnt, 2);
        do_start("ab_restart", 20'h54321, 8'd1);
        check("ab_restart_flag", abort_flag, 0);
        do_stop("ab_restop");

        // ---- rev_target = 0 behaves as 1; address stays latched ----
        do_start("rev0_start", 20'h00777, 8'd0);
        mcu_addr_base = 20'hFFFFF;
        sync_pulse("rev0_s1", 5, 10);
        check("rev0_busy1", busy, 1);
        sync_pulse("rev0_s2", 5, 10);
        check("rev0_done", smp_if.sample_end, 1);
        check("rev0_addr", smp_if.addr_base, 20'h00777);
        do_stop("rev0_stop");

        // ---- randomized runs ----
        for (int r = 0; r < 20; r++) begin
            int n;
            do_start("rnd_start", 20'($urandom), 8'($urandom_range(0, 5)));
            n = $urandom_range(0, 7);
            for (int p = 0; p < n; p++) begin
                if ($urandom_range(0, 2) == 0) sync_glitch("rnd_glitch", $urandom_range(1, FILT - 1));
                if ($urandom_range(0, 7) == 0) rev_target = 8'($urandom_range(0, 5));
                if ($urandom_range(0, 3) == 0) mcu_addr_base = 20'($urandom);
                sync_pulse("rnd_sync", $urandom_range(FILT + 1, 12), $urandom_range(8, 20));
            end
            do_stop("rnd_stop");
        end

        // ---- reset in the middle of a run (sync_cnt = 3) ----
        do_start("mr_start", 20'h0BEEF, 8'd5);
        sync_pulse("mr_s1", 6, 9);
        sync_pulse("mr_s2", 6, 9);
        sync_pulse("mr_s3", 6, 9);
        check("mr_cnt3", smp_if.sync_cnt, 3);
        mcu_n_rst = 1'b0;
        mcu_start = 1'b0;
        tick(1);
        model_reset();
        check_all("mr_rst");
        check("mr_sgn",  smp_if.ch_sgn_in,  0);
        check("mr_sync", smp_if.ch_sync_in, 0);
        mcu_n_rst = 1'b1;
        tick(4);
        check_all("mr_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/encoder_acq_ctrl.md
Name: encoder_acq_ctrl

Overview:
Upstream control stage for the encoder sample/RAM-write block. It conditions the raw encoder signal and sync inputs: 2-FF synchroniser plus stable-count glitch filter. It sequences one acquisition run on an MCU request, producing ch_sgn_in, ch_sync_in, sample_en, sample_end, sync_cnt and addr_base for the downstream sampler. It also hands the external RAM back to the MCU (sample_end=1) when the run completes, times out or is aborted.

Parameters:
FILT_LEN, 4, consecutive stable cycles required before a filtered output follows its input (1..15)
TO_W, 24, width of the no-sync timeout counter
TIMEOUT_CYC, 24'd10_000_000, cycles without a filtered sync rising edge before the run ends with timeout

Ports:
clk  in  1  system clock; all logic on rising edge
mcu_n_rst  in  1  asynchronous active-low reset
ch_sgn_raw  in  1  raw encoder signal, asynchronous
ch_sync_raw  in  1  raw encoder index/sync, asynchronous
mcu_start  in  1  MCU acquisition request level, asynchronous; rising edge starts, falling edge aborts
mcu_addr_base  in  20  RAM base address, latched at start
rev_target  in  8  revolutions to capture (0 treated as 1)
ch_sgn_in  out  1  filtered signal to sampler
ch_sync_in  out  1  filtered sync to sampler
sample_en  out  1  sampler enable
sample_end  out  1  1 = MCU owns RAM
sync_cnt  out  8  filtered sync rising edges seen this run, saturating at 255
addr_base  out  20  latched base address
busy  out  1  state is ARM or RUN
timeout_flag  out  1  last run ended by timeout
abort_flag  out  1  last run ended by MCU abort

Behaviour:
- Reset (async, mcu_n_rst=0):
  - state=IDLE, sample_en=0, sample_end=1, sync_cnt=0, addr_base=0.
  - Filtered outputs 0, both flags 0, all counters 0.
- Input path, per channel (sgn, sync, and mcu_start):
  - 2-FF synchroniser.
  - Filter (sgn, sync only): a 4-bit counter increments while the synced input differs from the filtered output, and clears when they match. When the counter reaches FILT_LEN-1 the output toggles and the counter clears.
  - Latency from a clean input edge to the filtered output: 2+FILT_LEN cycles.
  - Pulses shorter than FILT_LEN cycles never reach the output.
  - The filter runs in every state.
- Edge detect: sync_rise = filtered sync 0->1 (registered previous value). start_rise and start_fall come from synced mcu_start.
- State machine:
  - IDLE:
    - sample_end=1, sample_en=0.
    - On start_rise: latch addr_base<=mcu_addr_base, clear sync_cnt, clear timeout counter, clear both flags, sample_end<=0, go ARM.
  - ARM:
    - sample_en=1, sample_end=0.
    - Waits for the first sync_rise: sync_cnt<=1, go RUN.
  - RUN:
    - Each sync_rise: sync_cnt<=sync_cnt+1 (saturating).
    - When a sync_rise makes sync_cnt equal eff_target+1 (eff_target = rev_target, or 1 if rev_target is 0), go DONE.
    - rev_target is sampled live; a change mid-run takes effect at the next sync_rise compare.
  - DONE:
    - sample_en<=0, sample_end<=1, busy=0, sync_cnt holds.
    - On start_rise: same actions as IDLE start, go ARM.
    - Never returns to IDLE except by reset.
- Timeout:
  - Counter clears on entry to ARM and on every sync_rise, and increments in ARM and RUN.
  - Reaching TIMEOUT_CYC-1: timeout_flag<=1, go DONE.
- Abort: start_fall in ARM or RUN -> abort_flag<=1, go DONE.
- Simultaneous events in the same cycle, priority order: abort > final sync edge completing the run > timeout. The final sync edge also clears the timeout.
- start_rise while busy is ignored.
- sample_end and sample_en are registered and never both 1. The transition cycle into DONE drops sample_en and raises sample_end together.

Decomposition:
- Shared package: state encoding constants (IDLE, ARM, RUN, DONE as a one-hot-free 2-bit encoding), TIMEOUT_CYC default, and FILT_LEN default. The sampler uses the same package for its state constants.
- One sub-module, sig_filter: synchroniser plus stable-count filter, parameter FILT_LEN. It is instantiated twice (sgn, sync).

Test Plan:
- Reset mid-RUN (sync_cnt=3) -> next cycle sample_en=0, sample_end=1, sync_cnt=0, filtered outputs 0, state IDLE.
- Glitch filter, FILT_LEN=4: ch_sgn_raw high for 3 cycles -> ch_sgn_in stays 0. High for 10 cycles -> ch_sgn_in rises exactly 6 cycles after the raw edge.
- Normal run:
  - Setup: rev_target=2, mcu_addr_base=20'h01000, start, then 3 clean sync pulses.
  - Required: addr_base=20'h01000, sample_en=1 from ARM, sync_cnt 1,2,3.
  - Required: sample_end=1 and sample_en=0 the cycle after the 3rd sync_rise, with both flags 0.
- Timeout, TIMEOUT_CYC=1000: start with no sync -> DONE after 1000 cycles in ARM, timeout_flag=1, sync_cnt=0.
- Abort: mcu_start falls in RUN with sync_cnt=2 -> abort_flag=1, sample_end=1, sync_cnt holds 2. A new rising start -> ARM with both flags cleared.
- rev_target=0 with 2 syncs -> DONE after the 2nd sync_rise. start_rise while busy -> addr_base unchanged, no restart.
